// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, register indices, scoreboard slot
// and the architectural reset image of the register file.
package pipe_pkg;

  typedef enum logic [5:0] {
    CALL = 6'b000001,
    ADDI = 6'b000100,
    STW  = 6'b010101,
    BLT  = 6'b010110,
    LDW  = 6'b010111,
    SUBI = 6'b011111,
    MUL  = 6'b100111,
    ADD  = 6'b110001,
    NOPE = 6'b111111
  } opcode_e;

  localparam logic [5:0] R0  = 6'd0,  R1  = 6'd1,  R2  = 6'd2,  R3  = 6'd3;
  localparam logic [5:0] R4  = 6'd4,  R5  = 6'd5,  R6  = 6'd6,  R7  = 6'd7;
  localparam logic [5:0] R8  = 6'd8,  R9  = 6'd9,  R10 = 6'd10, R11 = 6'd11;
  localparam logic [5:0] R12 = 6'd12, R13 = 6'd13, R14 = 6'd14, R15 = 6'd15;
  localparam logic [5:0] R16 = 6'd16, R17 = 6'd17, R18 = 6'd18, R19 = 6'd19;
  localparam logic [5:0] R20 = 6'd20, R21 = 6'd21, R22 = 6'd22, R23 = 6'd23;
  localparam logic [5:0] R24 = 6'd24, R25 = 6'd25, R26 = 6'd26, R27 = 6'd27;
  localparam logic [5:0] R28 = 6'd28, R29 = 6'd29, R30 = 6'd30, R31 = 6'd31;

  typedef struct packed {
    logic       valid;
    logic [5:0] wreg;
  } sb_slot_t;

  function automatic logic [31:0] reg_reset_value(input logic [5:0] idx);
    case (idx)
      R4:      return 32'd3;
      R29:     return 32'h51;
      R30:     return 32'd150;
      R31:     return 32'd190;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports with
// same-cycle write-back bypass, one write port, fixed reset image.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [5:0]    ra_idx_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [5:0]    rb_idx_i,
  output logic [DW-1:0] rb_data_o,
  input  logic          we_i,
  input  logic [5:0]    wa_i,
  input  logic [DW-1:0] wd_i
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [DW-1:0] mem_q [NREGS];
  logic          wr_ok;

  assign wr_ok = we_i && (32'(wa_i) < NREGS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= DW'(reg_reset_value(6'(i)));
      end
    end else if (wr_ok) begin
      mem_q[wa_i[AW-1:0]] <= wd_i;
    end
  end

  // Out-of-range indices read as zero and never hit the bypass.
  assign ra_data_o = (32'(ra_idx_i) >= NREGS) ? '0 :
                     (wr_ok && (wa_i == ra_idx_i)) ? wd_i : mem_q[ra_idx_i[AW-1:0]];
  assign rb_data_o = (32'(rb_idx_i) >= NREGS) ? '0 :
                     (wr_ok && (wa_i == rb_idx_i)) ? wd_i : mem_q[rb_idx_i[AW-1:0]];

endmodule

// File: rtl/reg_read_stage.sv
// Decode-side register read stage: operand fetch, RAW scoreboard stall,
// and the registered ID/EX pipeline register.
module reg_read_stage
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned IMMW  = 16
) (
  input  logic            clk_46,
  input  logic            rst_46,
  input  logic            in_valid_46,
  input  logic [5:0]      opcode_46,
  input  logic [5:0]      src_reg_46,
  input  logic [5:0]      dest_reg_46,
  input  logic [5:0]      targ_reg_46,
  input  logic [IMMW-1:0] imm_46,
  output logic            stall_46,
  input  logic            flush_46,
  input  logic            wb_en_46,
  input  logic [5:0]      wb_reg_46,
  input  logic [DW-1:0]   wb_data_46,
  output logic            ex_valid_46,
  output logic [5:0]      ex_opcode_46,
  output logic            ex_wen_46,
  output logic [5:0]      ex_wreg_46,
  output logic [DW-1:0]   ex_opa_46,
  output logic [DW-1:0]   ex_opb_46,
  output logic [DW-1:0]   ex_imm_46
);

  logic            use_a, use_b, dec_wen, dec_ok;
  logic [5:0]      dec_wreg;
  logic [DW-1:0]   rd_a, rd_b;
  logic            hz_a, hz_b, issue;
  sb_slot_t        sb_ex_q, sb_ex_d, sb_mem_q;

  logic            ex_valid_q, ex_wen_q;
  logic [5:0]      ex_opcode_q, ex_wreg_q;
  logic [DW-1:0]   ex_opa_q, ex_opb_q, ex_imm_q;

  regfile_2r1w #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk_i     (clk_46),
    .rst_ni    (rst_46),
    .ra_idx_i  (src_reg_46),
    .ra_data_o (rd_a),
    .rb_idx_i  (dest_reg_46),
    .rb_data_o (rd_b),
    .we_i      (wb_en_46),
    .wa_i      (wb_reg_46),
    .wd_i      (wb_data_46)
  );

  always_comb begin
    use_a    = 1'b0;
    use_b    = 1'b0;
    dec_wen  = 1'b0;
    dec_wreg = '0;
    dec_ok   = 1'b1;
    case (opcode_46)
      ADD, MUL:        begin use_a = 1'b1; use_b = 1'b1; dec_wen = 1'b1; dec_wreg = targ_reg_46; end
      ADDI, SUBI, LDW: begin use_a = 1'b1; dec_wen = 1'b1; dec_wreg = dest_reg_46; end
      STW, BLT:        begin use_a = 1'b1; use_b = 1'b1; end
      CALL:            begin dec_wen = 1'b1; dec_wreg = R31; end
      default:         dec_ok = 1'b0;
    endcase
  end

  function automatic logic pending(input logic [5:0] idx, input sb_slot_t s0, input sb_slot_t s1);
    return (32'(idx) < NREGS) && ((s0.valid && (s0.wreg == idx)) || (s1.valid && (s1.wreg == idx)));
  endfunction

  assign hz_a     = use_a && pending(src_reg_46, sb_ex_q, sb_mem_q);
  assign hz_b     = use_b && pending(dest_reg_46, sb_ex_q, sb_mem_q);
  assign stall_46 = in_valid_46 && !flush_46 && (hz_a || hz_b);
  assign issue    = in_valid_46 && !flush_46 && !stall_46 && dec_ok;

  always_comb begin
    sb_ex_d = '0;
    if (issue && dec_wen) sb_ex_d = '{valid: 1'b1, wreg: dec_wreg};
  end

  // Every non-issue cycle (stall, flush, idle, undefined opcode) loads a clean bubble.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) begin
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= NOPE;
      ex_wen_q    <= 1'b0;
      ex_wreg_q   <= '0;
      ex_opa_q    <= '0;
      ex_opb_q    <= '0;
      ex_imm_q    <= '0;
    end else begin
      sb_mem_q   <= sb_ex_q;
      sb_ex_q    <= sb_ex_d;
      ex_valid_q <= issue;
      if (issue) begin
        ex_opcode_q <= opcode_46;
        ex_wen_q    <= dec_wen;
        ex_wreg_q   <= dec_wreg;
        ex_opa_q    <= use_a ? rd_a : '0;
        ex_opb_q    <= use_b ? rd_b : '0;
        ex_imm_q    <= {{(DW-IMMW){imm_46[IMMW-1]}}, imm_46};
      end else begin
        ex_opcode_q <= NOPE;
        ex_wen_q    <= 1'b0;
        ex_wreg_q   <= '0;
        ex_opa_q    <= '0;
        ex_opb_q    <= '0;
        ex_imm_q    <= '0;
      end
    end
  end

  assign ex_valid_46  = ex_valid_q;
  assign ex_opcode_46 = ex_opcode_q;
  assign ex_wen_46    = ex_wen_q;
  assign ex_wreg_46   = ex_wreg_q;
  assign ex_opa_46    = ex_opa_q;
  assign ex_opb_46    = ex_opb_q;
  assign ex_imm_46    = ex_imm_q;

endmodule
